mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Synchronous word-addressed RAM that services the datapath's memory requests: the responder end of the MAR/MDR interface whose MData_In side the datapath consumes.
- Accepts a Read or Write strobe with an address (from MAR) and write data (from MDR).
- Inserts a configurable number of wait states, then performs the access.
- Returns read data on Data_Out (wired to the datapath's MData_In) and signals completion with a one-cycle Done pulse.

Parameters:
ADDR_WIDTH, 9, address bits; DEPTH = 2**ADDR_WIDTH words (512)
DATA_WIDTH, 32, word width
WAIT_STATES, 1, cycles spent in WAIT before ACCESS; legal range 0..7
INIT_FILE, "", hex preload file read at elaboration; empty string means no preload

Ports:
Clock  input  1  rising-edge clock
Clear  input  1  synchronous active-high reset
Read  input  1  read request, level; sampled in IDLE
Write  input  1  write request, level; sampled in IDLE
Address  input  ADDR_WIDTH  word address; sampled at acceptance
Data_In  input  DATA_WIDTH  write data; sampled at acceptance
Data_Out  output  DATA_WIDTH  last read word; feeds datapath MData_In
Done  output  1  one-cycle completion pulse
Busy  output  1  high in WAIT and ACCESS
Error  output  1  one-cycle pulse, concurrent with Done, for an illegal request

Behaviour:
- Clock and reset:
  - Single clock domain. All state changes on the rising Clock edge.
- Clear (synchronous, active-high):
  - Forces state IDLE, Data_Out=0, Done=0, Busy=0, Error=0, wait counter=0, armed=1.
  - RAM contents are NOT cleared.
  - Clear beats every other input in the same cycle.
- States: IDLE, WAIT, ACCESS, RESP.
- Armed flag (re-arm rule):
  - Set on any edge where Read=0 and Write=0.
  - Cleared on acceptance.
  - A request held high after completion is not serviced twice; the requester must drop the request for at least one cycle.
- IDLE:
  - Request accepted at an edge when armed=1 and (Read xor Write)=1.
  - On acceptance, latch op, Address and Data_In.
  - Go to WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0; otherwise go directly to ACCESS.
- Illegal request (Read=1 and Write=1 while armed in IDLE):
  - Go to RESP with Done=1 and Error=1.
  - No RAM change; Data_Out unchanged; armed cleared.
- WAIT:
  - Busy=1. Decrement the counter each edge.
  - Go to ACCESS on the edge where counter=0.
  - Inputs ignored; changes to Address/Data_In/Read/Write during WAIT have no effect.
- ACCESS:
  - Busy=1.
  - On exit edge: write op stores the latched data at the latched address; read op registers RAM[address] into Data_Out.
  - Next state RESP.
- RESP:
  - Done=1 (and Error=1 only if illegal), Busy=0, for exactly one cycle, then IDLE.
  - Data_Out is valid while Done=1 and holds until the next completed read or Clear.
  - A write leaves Data_Out unchanged.
- Latency:
  - Acceptance at edge E0 gives Done high in the cycle following edge E(WAIT_STATES+1).
  - WAIT_STATES=1: Done high 2 cycles after acceptance. WAIT_STATES=0: Done high 1 cycle after acceptance.
- Back-to-back requests:
  - Minimum spacing between accepted requests is WAIT_STATES+4 edges (RESP, IDLE with drop, re-arm).
  - No request is accepted in RESP.
- Clear mid-operation:
  - Clear in WAIT or ACCESS aborts the request: no RAM write, no Done.
  - Clear on the ACCESS exit edge also suppresses the write.
- Address:
  - Full ADDR_WIDTH range is valid; no wrap handling is needed.
- Read-after-write to the same address returns the new data.

Test Plan:
1. Clear, then Write=1, Address=9'h012, Data_In=32'hE0000000, drop Write after Done -> Busy high for 2 cycles, Done one cycle, Error=0, Data_Out stays 0.
2. Read=1, Address=9'h012 -> Done 2 cycles after acceptance, Data_Out=32'hE0000000, held after Read drops.
3. Hold Read=1 for 10 cycles at address 9'h003 (preloaded 32'h40000000) -> exactly one Done pulse; Data_Out=32'h40000000.
4. Read=1 and Write=1 together, Data_In=32'hFFFFFFFF, Address=9'h012 -> Done=1 and Error=1 same cycle; a subsequent read of 9'h012 returns 32'hE0000000.
5. Write 32'h00000020 to 9'h1FF, assert Clear during WAIT -> no Done; a read of 9'h1FF returns the prior contents; Data_Out=0 after Clear.
6. WAIT_STATES=0 build: Read of 9'h012 -> Done 1 cycle after acceptance with 32'hE0000000; WAIT_STATES=3 build -> Done 4 cycles after acceptance.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed RAM responder with wait states, one-shot request handshake
// Serves MAR/MDR read/write requests; Data_Out feeds the datapath MData_In.
module mem_responder #(
    parameter int    ADDR_WIDTH  = 9,
    parameter int    DATA_WIDTH  = 32,
    parameter int    WAIT_STATES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] Data_In,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Done,
    output logic                  Busy,
    output logic                  Error
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [2:0] WAIT_INIT = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam bit HAS_WAIT = (WAIT_STATES > 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  armed_q, armed_d;
    logic                  op_write_q, op_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  error_q, error_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        armed_d    = armed_q;
        op_write_d = op_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        error_d    = 1'b0;

        // A request must be dropped for a cycle before the next one is honoured.
        if (!Read && !Write) begin
            armed_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (armed_q && (Read || Write)) begin
                    armed_d = 1'b0;
                    if (Read && Write) begin
                        state_d = S_RESP;
                        error_d = 1'b1;
                    end else begin
                        op_write_d = Write;
                        addr_d     = Address;
                        wdata_d    = Data_In;
                        if (HAS_WAIT) begin
                            state_d = S_WAIT;
                            cnt_d   = WAIT_INIT;
                        end else begin
                            state_d = S_ACCESS;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                if (!op_write_q) begin
                    data_out_d = mem[addr_q];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_RESP);
        busy_d = (state_d == S_WAIT) || (state_d == S_ACCESS);
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            armed_q    <= 1'b1;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
        end
    end

    // RAM contents survive Clear; Clear on the ACCESS exit edge still blocks the write.
    always_ff @(posedge Clock) begin
        if (!Clear && (state_q == S_ACCESS) && op_write_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign Data_Out = data_out_q;
    assign Done     = done_q;
    assign Busy     = busy_q;
    assign Error    = error_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed bench for mem_responder at WAIT_STATES 1, 0 and 3
module tb_mem_responder;
    logic        Clock;
    logic        Clear;
    logic        Read;
    logic        Write;
    logic [8:0]  Address;
    logic [31:0] Data_In;
    logic [31:0] dout1, dout0, dout3;
    logic        done1, done0, done3;
    logic        busy1, busy0, busy3;
    logic        err1, err0, err3;

    int checks = 0;
    int fails  = 0;

    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(1), .INIT_FILE("")) dut (
        .Clock(Clock), .Clear(Clear), .Read(Read), .Write(Write), .Address(Address),
        .Data_In(Data_In), .Data_Out(dout1), .Done(done1), .Busy(busy1), .Error(err1)
    );
    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
        .Clock(Clock), .Clear(Clear), .Read(Read), .Write(Write), .Address(Address),
        .Data_In(Data_In), .Data_Out(dout0), .Done(done0), .Busy(busy0), .Error(err0)
    );
    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(3), .INIT_FILE("")) dut3 (
        .Clock(Clock), .Clear(Clear), .Read(Read), .Write(Write), .Address(Address),
        .Data_In(Data_In), .Data_Out(dout3), .Done(done3), .Busy(busy3), .Error(err3)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_gap(input int n);
        Read  = 1'b0;
        Write = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Issues one request on the shared inputs and returns the main-instance Done latency.
    task automatic do_op(input logic rd, input logic wr, input logic [8:0] a,
                         input logic [31:0] d, output int lat);
        Read    = rd;
        Write   = wr;
        Address = a;
        Data_In = d;
        tick();
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (done1) begin
                lat = c;
                break;
            end
        end
    endtask

    int lat;
    int pulses;
    int lat0, lat1, lat3;
    logic [31:0] d0, d1, d3;

    initial begin
        Clear = 1'b1; Read = 1'b0; Write = 1'b0; Address = '0; Data_In = '0;
        tick(); tick();
        Clear = 1'b0;
        check("reset_data_out", dout1, 32'h0);
        check("reset_done", {31'b0, done1}, 32'h0);
        check("reset_busy", {31'b0, busy1}, 32'h0);
        check("reset_error", {31'b0, err1}, 32'h0);

        // Test 1: write with explicit cycle-by-cycle checks
        Write = 1'b1; Address = 9'h012; Data_In = 32'hE0000000;
        tick();
        check("t1_busy_c1", {31'b0, busy1}, 32'h1);
        check("t1_done_c1", {31'b0, done1}, 32'h0);
        tick();
        check("t1_busy_c2", {31'b0, busy1}, 32'h1);
        tick();
        check("t1_done", {31'b0, done1}, 32'h1);
        check("t1_busy_resp", {31'b0, busy1}, 32'h0);
        check("t1_error", {31'b0, err1}, 32'h0);
        check("t1_data_out", dout1, 32'h0);
        Write = 1'b0;
        tick();
        check("t1_done_drop", {31'b0, done1}, 32'h0);
        idle_gap(6);

        // Test 2: read back
        do_op(1'b1, 1'b0, 9'h012, 32'h0, lat);
        check("t2_latency", lat, 2);
        check("t2_data", dout1, 32'hE0000000);
        idle_gap(3);
        check("t2_data_held", dout1, 32'hE0000000);
        idle_gap(3);

        // Seed address 3 (no preload file in this bench)
        do_op(1'b0, 1'b1, 9'h003, 32'h40000000, lat);
        check("seed_latency", lat, 2);
        idle_gap(6);

        // Test 3: held Read yields exactly one Done
        Read = 1'b1; Address = 9'h003;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done1) pulses++;
        end
        check("t3_pulses", pulses, 1);
        check("t3_data", dout1, 32'h40000000);
        idle_gap(6);

        // Test 4: illegal Read+Write
        Read = 1'b1; Write = 1'b1; Address = 9'h012; Data_In = 32'hFFFFFFFF;
        tick();
        check("t4_done", {31'b0, done1}, 32'h1);
        check("t4_error", {31'b0, err1}, 32'h1);
        check("t4_data_unchanged", dout1, 32'h40000000);
        idle_gap(6);
        do_op(1'b1, 1'b0, 9'h012, 32'h0, lat);
        check("t4_readback", dout1, 32'hE0000000);
        idle_gap(6);

        // Test 5: Clear during WAIT aborts a write to the top address
        do_op(1'b0, 1'b1, 9'h1FF, 32'h12345678, lat);
        idle_gap(6);
        Write = 1'b1; Address = 9'h1FF; Data_In = 32'h00000020;
        tick();
        check("t5_busy", {31'b0, busy1}, 32'h1);
        Clear = 1'b1; Write = 1'b0;
        tick();
        Clear = 1'b0;
        check("t5_data_cleared", dout1, 32'h0);
        check("t5_busy_cleared", {31'b0, busy1}, 32'h0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done1) pulses++;
        end
        check("t5_no_done", pulses, 0);
        do_op(1'b1, 1'b0, 9'h1FF, 32'h0, lat);
        check("t5_readback", dout1, 32'h12345678);
        idle_gap(8);

        // Test 6: latency across WAIT_STATES builds
        Read = 1'b1; Address = 9'h012;
        tick();
        lat0 = 0; lat1 = 0; lat3 = 0; d0 = '0; d1 = '0; d3 = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (done0 && lat0 == 0) begin lat0 = c; d0 = dout0; end
            if (done1 && lat1 == 0) begin lat1 = c; d1 = dout1; end
            if (done3 && lat3 == 0) begin lat3 = c; d3 = dout3; end
        end
        check("t6_ws0_latency", lat0, 1);
        check("t6_ws1_latency", lat1, 2);
        check("t6_ws3_latency", lat3, 4);
        check("t6_ws0_data", d0, 32'hE0000000);
        check("t6_ws3_data", d3, 32'hE0000000);
        check("t6_ws1_data", d1, 32'hE0000000);
        idle_gap(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
